// File: rtl/uart_pkg.sv
// Shared constants, receiver state encoding and parity helper for the UART RX.
// Break detection is compiled in with UART_RX_BREAK_DET_EN.
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'd0;
    localparam logic [1:0] PARITY_ODD  = 2'd1;
    localparam logic [1:0] PARITY_EVEN = 2'd2;

    typedef logic [2:0] rx_state_t;

    localparam rx_state_t ST_IDLE   = 3'd0;
    localparam rx_state_t ST_START  = 3'd1;
    localparam rx_state_t ST_DATA   = 3'd2;
    localparam rx_state_t ST_PARITY = 3'd3;
    localparam rx_state_t ST_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
    localparam rx_state_t ST_BREAK  = 3'd5;
`endif

    // Expected parity bit for up to 9 data bits (zero-extended).
    function automatic logic parity_bit(
        input logic [8:0] data,
        input logic [1:0] mode
    );
        logic p;
        p = ^data;
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-side delivery bundle: holding register outputs, status pulses
// and the consumer's ready.
interface uart_rx_os_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  parity_err;
    logic                  frame_err;
    logic                  overrun;
    logic                  rx_break;

    modport master (
        output rx_data,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        output rx_break,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        input  rx_break,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync_vote.sv
// Serial line synchroniser, falling-edge detect and 3-sample majority.
// All flops reset to the idle (high) line level.
module uart_rx_sync_vote
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic data_in,
    output logic line,
    output logic fall,
    output logic vote
);

    logic s1;
    logic s2;
    logic prev;
    logic prev2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            prev  <= 1'b1;
            prev2 <= 1'b1;
        end else begin
            s1    <= data_in;
            s2    <= s1;
            prev  <= s2;
            prev2 <= prev;
        end
    end

    assign line = s2;
    assign fall = prev & ~s2;

    // Majority over the current and two previous synced samples.
    assign vote = (prev2 & prev) | (prev2 & s2) | (prev & s2);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with one-entry valid/ready holding register.
// Define UART_RX_BREAK_DET_EN to enable line-break detection (rx_break).
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_WIDTH  = 1
) (
    input  logic         rx_clk,
    input  logic         rst,
    input  logic         data_in,
    uart_rx_os_if.master bus
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] OS_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] VOTE_AT = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_WIDTH - 1);
    localparam logic [1:0]    PMODE = 2'(PARITY_MODE);

    logic line;
    logic fall;
    logic vote;

    rx_state_t             state;
    logic [CW-1:0]         os_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_err_q;
    logic                  ferr_q;

    logic                  vote_now;
    logic                  wrap;
    logic                  stop_vote;
    logic                  final_stop;
    logic                  brk_hit;
    logic                  done;
    logic                  load;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  perr_q;
    logic                  fout_q;
    logic                  ovr_q;

    uart_rx_sync_vote u_sync (
        .clk     (rx_clk),
        .rst     (rst),
        .data_in (data_in),
        .line    (line),
        .fall    (fall),
        .vote    (vote)
    );

    assign vote_now   = (os_cnt == VOTE_AT);
    assign wrap       = (os_cnt == OS_LAST);
    assign stop_vote  = (state == ST_STOP) && vote_now;
    assign final_stop = stop_vote && (bit_cnt == STOP_LAST);

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit_q;
    logic brk_q;

    assign brk_hit = stop_vote && (bit_cnt == '0) && !vote &&
                     (shreg == '0) &&
                     ((PMODE == PARITY_NONE) || !par_bit_q);
`else
    logic line_unused;

    assign line_unused = line;
    assign brk_hit     = 1'b0;
`endif

    assign done = final_stop && !brk_hit;
    assign load = done && (!valid_q || bus.rx_ready);

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            os_cnt    <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_err_q <= 1'b0;
            ferr_q    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q <= 1'b0;
`endif
        end else begin
            os_cnt <= wrap ? '0 : os_cnt + 1'b1;
            case (state)
                ST_IDLE: begin
                    os_cnt <= fall ? CW'(1) : '0;
                    if (fall) state <= ST_START;
                end
                ST_START: begin
                    if (vote_now && vote) begin
                        state  <= ST_IDLE;
                        os_cnt <= '0;
                    end else if (wrap) begin
                        state     <= ST_DATA;
                        bit_cnt   <= '0;
                        par_err_q <= 1'b0;
                        ferr_q    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (vote_now) begin
                        shreg   <= {vote, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (wrap && bit_cnt == BIT_LAST) begin
                        bit_cnt <= '0;
                        state   <= (PMODE != PARITY_NONE) ?
                                   ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (vote_now) begin
                        par_err_q <= vote !=
                            parity_bit(9'(shreg), PMODE);
`ifdef UART_RX_BREAK_DET_EN
                        par_bit_q <= vote;
`endif
                    end
                    if (wrap) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (stop_vote && !vote) ferr_q <= 1'b1;
                    // Leave half a bit early so the next start edge is seen.
                    if (brk_hit) begin
`ifdef UART_RX_BREAK_DET_EN
                        state   <= ST_BREAK;
`endif
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end else if (final_stop) begin
                        state   <= ST_IDLE;
                        os_cnt  <= '0;
                        bit_cnt <= '0;
                    end else if (stop_vote) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_BREAK_DET_EN
                ST_BREAK: begin
                    os_cnt <= '0;
                    if (line) state <= ST_IDLE;
                end
`endif
                default: begin
                    state  <= ST_IDLE;
                    os_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            fout_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ovr_q <= done && valid_q && !bus.rx_ready;
            if (load) begin
                data_q  <= shreg;
                perr_q  <= par_err_q;
                fout_q  <= ferr_q | ~vote;
                valid_q <= 1'b1;
            end else if (valid_q && bus.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    always_ff @(posedge rx_clk) begin
        if (rst) brk_q <= 1'b0;
        else     brk_q <= brk_hit;
    end

    assign bus.rx_break = brk_q;
`else
    assign bus.rx_break = 1'b0;
`endif

    assign bus.rx_data    = data_q;
    assign bus.rx_valid   = valid_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = fout_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: two configurations (8E1 x16, 7O2 x8) against a
// frame-timing model; break expectations follow UART_RX_BREAK_DET_EN.
module tb_uart_rx_os;

    localparam int DW0 = 8, OS0 = 16, PM0 = 2, SW0 = 1;
    localparam int DW1 = 7, OS1 = 8,  PM1 = 1, SW1 = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] line = 2'b11;
    logic       rdy [2];

    always #5 clk = ~clk;

    uart_rx_os_if #(.DATA_WIDTH(DW0)) bus0 ();
    uart_rx_os_if #(.DATA_WIDTH(DW1)) bus1 ();

    assign bus0.rx_ready = rdy[0];
    assign bus1.rx_ready = rdy[1];

    uart_rx_os #(
        .DATA_WIDTH(DW0), .OVERSAMPLE(OS0),
        .PARITY_MODE(PM0), .STOP_WIDTH(SW0)
    ) dut0 (
        .rx_clk(clk), .rst(rst), .data_in(line[0]), .bus(bus0.master)
    );

    uart_rx_os #(
        .DATA_WIDTH(DW1), .OVERSAMPLE(OS1),
        .PARITY_MODE(PM1), .STOP_WIDTH(SW1)
    ) dut1 (
        .rx_clk(clk), .rst(rst), .data_in(line[1]), .bus(bus1.master)
    );

    typedef struct {
        int         cyc;
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       brk;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } rise_t;

    ev_t   evq0[$];
    ev_t   evq1[$];
    rise_t rq0[$];
    rise_t rq1[$];

    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic chk_en = 1'b0;
    int   ovr_cnt [2];
    int   brk_cnt [2];

    logic [8:0] a_d [2];
    logic       a_v [2], a_pe [2], a_fe [2], a_ov [2], a_bk [2];

    assign a_d[0]  = 9'(bus0.rx_data);
    assign a_v[0]  = bus0.rx_valid;
    assign a_pe[0] = bus0.parity_err;
    assign a_fe[0] = bus0.frame_err;
    assign a_ov[0] = bus0.overrun;
    assign a_bk[0] = bus0.rx_break;
    assign a_d[1]  = 9'(bus1.rx_data);
    assign a_v[1]  = bus1.rx_valid;
    assign a_pe[1] = bus1.parity_err;
    assign a_fe[1] = bus1.frame_err;
    assign a_ov[1] = bus1.overrun;
    assign a_bk[1] = bus1.rx_break;

    logic       mv [2], mpe [2], mfe [2], mov [2], mbk [2];
    logic [8:0] md [2];
    logic       pv [2];
    ev_t        e_m;
    logic       hit_m;

    function automatic int dw(input int u); return u ? DW1 : DW0; endfunction
    function automatic int os(input int u); return u ? OS1 : OS0; endfunction
    function automatic int pm(input int u); return u ? PM1 : PM0; endfunction
    function automatic int sw(input int u); return u ? SW1 : SW0; endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Model: delivery/overrun/break at the final (or break) stop vote cycle.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            mov[u] = 1'b0;
            mbk[u] = 1'b0;
            hit_m  = 1'b0;
            if (u == 0 && evq0.size() > 0 && evq0[0].cyc == cyc) begin
                e_m = evq0.pop_front(); hit_m = 1'b1;
            end
            if (u == 1 && evq1.size() > 0 && evq1[0].cyc == cyc) begin
                e_m = evq1.pop_front(); hit_m = 1'b1;
            end
            if (rst) begin
                mv[u] = 0; md[u] = 0; mpe[u] = 0; mfe[u] = 0;
            end else if (hit_m && e_m.brk) begin
                mbk[u] = 1'b1;
            end else if (hit_m && mv[u] && !rdy[u]) begin
                mov[u] = 1'b1;
            end else if (hit_m) begin
                mv[u] = 1'b1; md[u] = e_m.d;
                mpe[u] = e_m.pe; mfe[u] = e_m.fe;
            end else if (mv[u] && rdy[u]) begin
                mv[u] = 1'b0;
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("valid%0d", u), 32'(a_v[u]), 32'(mv[u]));
                if (mv[u]) begin
                    chk($sformatf("data%0d", u), 32'(a_d[u]), 32'(md[u]));
                    chk($sformatf("perr%0d", u), 32'(a_pe[u]), 32'(mpe[u]));
                    chk($sformatf("ferr%0d", u), 32'(a_fe[u]), 32'(mfe[u]));
                end
                chk($sformatf("overrun%0d", u), 32'(a_ov[u]), 32'(mov[u]));
                chk($sformatf("break%0d", u), 32'(a_bk[u]), 32'(mbk[u]));
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (chk_en && a_v[u] === 1'b1 && pv[u] !== 1'b1) begin
                if (u == 0) rq0.push_back('{cyc, a_d[u], a_pe[u], a_fe[u]});
                else        rq1.push_back('{cyc, a_d[u], a_pe[u], a_fe[u]});
            end
            pv[u] = a_v[u];
            if (chk_en && a_ov[u] === 1'b1) ovr_cnt[u]++;
            if (chk_en && a_bk[u] === 1'b1) brk_cnt[u]++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame; glitch_bit = frame bit index that gets a one-cycle
    // low at its centre; hold = extra low cycles; abort_at >= 0 cuts it off.
    task automatic send(input int u, input logic [8:0] d, input logic pflip,
                        input logic [1:0] stops, input int glitch_bit,
                        input int hold, input int abort_at,
                        output int e_cyc);
        logic bits[$];
        logic pb, v, aborted;
        int   nb, n_os, m, k;
        ev_t  ev;
        n_os = os(u);
        m    = n_os / 2;
        pb   = (pm(u) == 2) ? logic'($countones(d) % 2)
                            : logic'(1 - $countones(d) % 2);
        pb   = pb ^ pflip;
        bits.push_back(1'b0);
        for (int i = 0; i < dw(u); i++) bits.push_back(d[i]);
        if (pm(u) != 0) bits.push_back(pb);
        bits.push_back(stops[0]);
        if (sw(u) == 2) bits.push_back(stops[1]);
        nb = bits.size();
        @(negedge clk);
        e_cyc  = cyc + 2;
        ev.d   = d;
        ev.pe  = (pm(u) != 0) && pflip;
        ev.fe  = !stops[0] || (sw(u) == 2 && !stops[1]);
        ev.brk = 1'b0;
        ev.cyc = e_cyc + (nb - 1) * n_os + m + 1;
`ifdef UART_RX_BREAK_DET_EN
        if (d == 0 && (pm(u) == 0 || !pb) && !stops[0]) begin
            ev.brk = 1'b1;
            ev.cyc = e_cyc + (nb - sw(u)) * n_os + m + 1;
        end
`endif
        if (abort_at < 0) begin
            if (u == 0) evq0.push_back(ev);
            else        evq1.push_back(ev);
        end
        aborted = 1'b0;
        for (int t = 0; t < nb * n_os + hold; t++) begin
            if (t > 0) @(negedge clk);
            if (t == abort_at) begin
                aborted = 1'b1;
                break;
            end
            k = t / n_os;
            v = (k < nb) ? bits[k] : 1'b0;
            if (k == glitch_bit && t % n_os == m) v = 1'b0;
            line[u] = v;
        end
        if (!aborted) @(negedge clk);
        line[u] = 1'b1;
    endtask

    task automatic expect_rise(input int u, input string nm, input int cy,
                               input logic [8:0] d, input logic pe,
                               input logic fe);
        rise_t r;
        int    sz;
        sz = (u == 0) ? rq0.size() : rq1.size();
        if (sz == 0) begin
            checks++;
            $display("FAIL %s: no rx_valid rise seen, required one at cycle %0d",
                     nm, cy);
        end else begin
            if (u == 0) r = rq0.pop_front();
            else        r = rq1.pop_front();
            chk({nm, "_cycle"}, r.cyc, cy);
            chk({nm, "_data"}, 32'(r.d), 32'(d));
            chk({nm, "_perr"}, 32'(r.pe), 32'(pe));
            chk({nm, "_ferr"}, 32'(r.fe), 32'(fe));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e, e2, n;
        for (int u = 0; u < 2; u++) begin
            rdy[u] = 1'b1; mv[u] = 0; md[u] = 0; mpe[u] = 0; mfe[u] = 0;
            mov[u] = 0; mbk[u] = 0; pv[u] = 0; ovr_cnt[u] = 0; brk_cnt[u] = 0;
        end
        rst = 1'b1;
        idle(4);
        chk("rst_valid0", 32'(a_v[0]), 0);
        chk("rst_data0", 32'(a_d[0]), 0);
        chk("rst_perr0", 32'(a_pe[0]), 0);
        chk("rst_ferr0", 32'(a_fe[0]), 0);
        chk("rst_ovr0", 32'(a_ov[0]), 0);
        chk("rst_brk0", 32'(a_bk[0]), 0);
        chk("rst_valid1", 32'(a_v[1]), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(5);

        send(0, 9'hA5, 1'b0, 2'b11, -1, 0, -1, e);
        idle(30);
        expect_rise(0, "a5", e + 170, 9'hA5, 1'b0, 1'b0);

        send(0, 9'h3C, 1'b0, 2'b11, 3, 0, -1, e);
        idle(30);
        expect_rise(0, "glitch", e + 170, 9'h3C, 1'b0, 1'b0);

        @(negedge clk);
        n = cyc;
        line[0] = 1'b0;
        idle(4);
        line[0] = 1'b1;
        while (cyc < n + 9) @(negedge clk);
        send(0, 9'h96, 1'b0, 2'b11, -1, 0, -1, e);
        idle(30);
        expect_rise(0, "false_start", n + 12 + 170, 9'h96, 1'b0, 1'b0);

        rdy[0] = 1'b0;
        send(0, 9'h11, 1'b0, 2'b11, -1, 0, -1, e);
        send(0, 9'h22, 1'b0, 2'b11, -1, 0, -1, e2);
        idle(20);
        expect_rise(0, "ovr_first", e + 170, 9'h11, 1'b0, 1'b0);
        chk("ovr_pulses", ovr_cnt[0], 1);
        chk("ovr_hold_data", 32'(a_d[0]), 32'h11);
        chk("ovr_hold_valid", 32'(a_v[0]), 1);
        rdy[0] = 1'b1;
        @(negedge clk);
        rdy[0] = 1'b0;
        chk("ovr_drain", 32'(a_v[0]), 0);
        rdy[0] = 1'b1;
        idle(5);

        send(1, 9'h3C, 1'b1, 2'b11, -1, 0, -1, e);
        idle(20);
        expect_rise(1, "odd_perr", e + 86, 9'h3C, 1'b1, 1'b0);

        send(1, 9'h15, 1'b0, 2'b01, -1, 0, -1, e);
        idle(20);
        expect_rise(1, "stop2_ferr", e + 86, 9'h15, 1'b0, 1'b1);

        send(0, 9'h00, 1'b0, 2'b00, -1, 2 * 11 * 16, -1, e);
        idle(20);
`ifdef UART_RX_BREAK_DET_EN
        chk("break_pulses", brk_cnt[0], 1);
`else
        expect_rise(0, "break_off", e + 170, 9'h00, 1'b0, 1'b1);
        chk("break_pulses", brk_cnt[0], 0);
`endif
        send(0, 9'h55, 1'b0, 2'b11, -1, 0, -1, e);
        idle(30);
        expect_rise(0, "after_break", e + 170, 9'h55, 1'b0, 1'b0);

        send(0, 9'hF0, 1'b0, 2'b11, -1, 0, 64, e);
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(5);
        send(0, 9'h0F, 1'b0, 2'b11, -1, 0, -1, e);
        idle(30);
        expect_rise(0, "after_reset", e + 170, 9'h0F, 1'b0, 1'b0);

        chk("stray_rise0", rq0.size(), 0);
        chk("stray_rise1", rq1.size(), 0);
        chk("overrun1", ovr_cnt[1], 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
